// File: rtl/bus_block_memory.sv
// Dual-port WIDTH x DEPTH memory mapped into the 16-bit debug bus as 16-bit chunks per word.
// Bus side: fixed 3-cycle pass-through, one txn/cycle, no backpressure; user side: 1-cycle read-first word port.
module bus_block_memory #(
    parameter logic [15:0] BASE_ADDR  = 16'h0000,
    parameter int          WIDTH      = 18,
    parameter int          DEPTH      = 256,
    localparam int         ADDR_WIDTH = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [15:0]           addr_i,
    input  logic [15:0]           wdata_i,
    input  logic [15:0]           rdata_i,
    input  logic                  rw_i,
    input  logic                  valid_i,
    output logic [15:0]           addr_o,
    output logic [15:0]           wdata_o,
    output logic [15:0]           rdata_o,
    output logic                  rw_o,
    output logic                  valid_o,
    input  logic [ADDR_WIDTH-1:0] user_addr,
    input  logic [WIDTH-1:0]      user_din,
    input  logic                  user_we,
    output logic [WIDTH-1:0]      user_dout
);

    localparam int N_CHUNKS = (WIDTH + 15) / 16;
    localparam int PW       = N_CHUNKS * 16;
    localparam int CW       = (N_CHUNKS > 1) ? $clog2(N_CHUNKS) : 1;
    localparam int MAX_ADDR = int'(BASE_ADDR) + DEPTH * N_CHUNKS - 1;
    localparam int REM      = WIDTH % 16;

    localparam logic [15:0]         TOP_MASK   = (REM == 0) ? 16'hFFFF : 16'((32'd1 << REM) - 32'd1);
    localparam logic [15:0]         MAX_A      = 16'(MAX_ADDR);
    localparam logic [15:0]         NCH16      = 16'(N_CHUNKS);
    localparam logic [CW-1:0]       LAST_CHUNK = CW'(N_CHUNKS - 1);
    localparam logic [ADDR_WIDTH:0] DEPTH_W    = (ADDR_WIDTH + 1)'(DEPTH);

    if (MAX_ADDR > 32'hFFFF || WIDTH < 1 || WIDTH > 256 || DEPTH < 2) begin : g_param_err
        $error("bus_block_memory: illegal WIDTH/DEPTH or address range exceeds 16'hFFFF");
    end

    typedef struct packed {
        logic [15:0] addr;
        logic [15:0] wdat;
        logic [15:0] rdat;
        logic        rw;
        logic        vld;
    } bus_t;

    // Words padded to whole chunks; unused top bits stay zero so partial-chunk reads zero-extend.
    logic [N_CHUNKS-1:0][15:0] r_mem [DEPTH];

    bus_t                  w_in;
    logic                  w_hit;
    logic [15:0]           w_off;
    logic [ADDR_WIDTH-1:0] w_word;
    logic [CW-1:0]         w_chunk;
    logic                  w_usr_ok;
    logic                  w_usr_wr;
    logic                  w_bus_wr;
    logic [15:0]           w_bus_wdat;

    bus_t                  r_s1;
    logic                  r_s1_hit;
    logic [ADDR_WIDTH-1:0] r_s1_word;
    logic [CW-1:0]         r_s1_chunk;
    bus_t                  r_s2;
    logic                  r_s2_hit;
    logic [15:0]           r_s2_rd;
    bus_t                  r_s3;
    logic [WIDTH-1:0]      r_udout;

    assign w_in    = '{addr: addr_i, wdat: wdata_i, rdat: rdata_i, rw: rw_i, vld: valid_i};
    assign w_hit   = (addr_i >= BASE_ADDR) && (addr_i <= MAX_A);
    assign w_off   = addr_i - BASE_ADDR;
    assign w_word  = ADDR_WIDTH'(w_off / NCH16);
    assign w_chunk = CW'(w_off % NCH16);

    assign w_usr_ok   = ({1'b0, user_addr} < DEPTH_W);
    assign w_usr_wr   = user_we && w_usr_ok;
    // A user write to the same word on the same edge owns every bit of it.
    assign w_bus_wr   = r_s1_hit && r_s1.rw && !(w_usr_wr && (user_addr == r_s1_word));
    assign w_bus_wdat = (r_s1_chunk == LAST_CHUNK) ? (r_s1.wdat & TOP_MASK) : r_s1.wdat;

    always_ff @(posedge clk) begin
        if (rst_n) begin
            if (w_bus_wr) begin
                r_mem[r_s1_word][r_s1_chunk] <= w_bus_wdat;
            end
            if (w_usr_wr) begin
                r_mem[user_addr] <= PW'(user_din);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_s1       <= '0;
            r_s1_hit   <= 1'b0;
            r_s1_word  <= '0;
            r_s1_chunk <= '0;
            r_s2       <= '0;
            r_s2_hit   <= 1'b0;
            r_s2_rd    <= '0;
            r_s3       <= '0;
            r_udout    <= '0;
        end else begin
            r_s1       <= w_in;
            r_s1_hit   <= valid_i && w_hit;
            r_s1_word  <= w_word;
            r_s1_chunk <= w_chunk;

            r_s2       <= r_s1;
            r_s2_hit   <= r_s1_hit;
            r_s2_rd    <= r_mem[r_s1_word][r_s1_chunk];

            r_s3 <= r_s2;
            if (r_s2_hit && !r_s2.rw) begin
                r_s3.rdat <= r_s2_rd;
            end

            r_udout <= w_usr_ok ? WIDTH'(r_mem[user_addr]) : '0;
        end
    end

    assign addr_o    = r_s3.addr;
    assign wdata_o   = r_s3.wdat;
    assign rdata_o   = r_s3.rdat;
    assign rw_o      = r_s3.rw;
    assign valid_o   = r_s3.vld;
    assign user_dout = r_udout;

endmodule
